pipeline_hazard_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage RV64 pipeline (IF, ID, EX, MEM, WB).
- Drives the per-stage stall inputs of fetch, decode, execute and memory stages, and the bubble/flush controls between them.
- Resolves register RAW hazards with a scoreboard over EX/MEM/WB destinations. There is no forwarding path.
- Sequences taken-branch redirect/flush and freezes the pipeline during data-memory wait handshakes.

---
 rtl/pipeline_pkg.sv | 11 +
 rtl/raw_hazard_detect.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types and widths
package pipeline_pkg;
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 64;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;
endpackage

// File: rtl/raw_hazard_detect.sv
// rtl/raw_hazard_detect.sv - ID source vs EX/MEM/WB destination scoreboard compare
module raw_hazard_detect
    import pipeline_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_reg_write,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 mem_reg_write,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_reg_write,
    output logic                 raw
);
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired zero, so a source of 0 can never depend on an older write
    assign rs1_hit = id_use_rs1 && (id_rs1 != '0) &&
                     ((ex_reg_write  && (ex_rd  == id_rs1)) ||
                      (mem_reg_write && (mem_rd == id_rs1)) ||
                      (wb_reg_write  && (wb_rd  == id_rs1)));

    assign rs2_hit = id_use_rs2 && (id_rs2 != '0) &&
                     ((ex_reg_write  && (ex_rd  == id_rs2)) ||
                      (mem_reg_write && (mem_rd == id_rs2)) ||
                      (wb_reg_write  && (wb_rd  == id_rs2)));

    assign raw = rs1_hit || rs2_hit;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush scheduler for the 5-stage pipeline
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_id_use_rs1,
    input  logic                 i_id_use_rs2,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_ex_reg_write,
    input  logic [REG_IDX_W-1:0] i_mem_rd,
    input  logic                 i_mem_reg_write,
    input  logic [REG_IDX_W-1:0] i_wb_rd,
    input  logic                 i_wb_reg_write,
    input  logic                 i_mem_branch_taken,
    input  logic [XLEN-1:0]      i_mem_jmp_addr,
    input  logic                 i_dmem_req,
    input  logic                 i_dmem_ready,
    output logic                 o_stall_if,
    output logic                 o_stall_id,
    output logic                 o_stall_ex,
    output logic                 o_stall_mem,
    output logic                 o_bubble_ex,
    output logic                 o_flush,
    output logic                 o_pc_sel,
    output logic [XLEN-1:0]      o_pc_target,
    output logic [1:0]           o_state,
    output logic [CNT_W-1:0]     o_stall_cnt,
    output logic [CNT_W-1:0]     o_flush_cnt
);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);

    hz_state_t        state_q, state_d;
    logic [2:0]       flush_left_q, flush_left_d;
    logic [XLEN-1:0]  target_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic raw;
    logic mem_wait;
    logic stall_all_c, stall_raw_c, flush_c, redirect_c;
    logic redirect;

    raw_hazard_detect u_raw (
        .id_rs1        (i_id_rs1),
        .id_rs2        (i_id_rs2),
        .id_use_rs1    (i_id_use_rs1),
        .id_use_rs2    (i_id_use_rs2),
        .ex_rd         (i_ex_rd),
        .ex_reg_write  (i_ex_reg_write),
        .mem_rd        (i_mem_rd),
        .mem_reg_write (i_mem_reg_write),
        .wb_rd         (i_wb_rd),
        .wb_reg_write  (i_wb_reg_write),
        .raw           (raw)
    );

    assign mem_wait = i_dmem_req && !i_dmem_ready;

    // Next-state and same-cycle control decode: memory wait > branch > RAW
    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        stall_all_c  = 1'b0;
        stall_raw_c  = 1'b0;
        flush_c      = 1'b0;
        redirect_c   = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    stall_all_c = 1'b1;
                    state_d     = MEM_WAIT;
                end else if (i_mem_branch_taken) begin
                    redirect_c = 1'b1;
                end else if (raw) begin
                    stall_raw_c = 1'b1;
                end
            end
            FLUSH: begin
                // Counter holds during a memory wait; RAW is moot since ID is squashed
                if (mem_wait) begin
                    stall_all_c = 1'b1;
                end else if (i_mem_branch_taken) begin
                    redirect_c = 1'b1;
                end else begin
                    flush_c      = 1'b1;
                    flush_left_d = flush_left_q - 3'd1;
                    if (flush_left_q <= 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                // The branch held in MEM is re-seen once we are back in RUN
                if (i_dmem_ready) begin
                    state_d = RUN;
                end else begin
                    stall_all_c = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (redirect_c) begin
            flush_c = 1'b1;
            if (FLUSH_MULTI) begin
                state_d      = FLUSH;
                flush_left_d = FLUSH_RELOAD;
            end else begin
                state_d = RUN;
            end
        end
    end

    assign redirect    = redirect_c && !i_rst;
    assign o_stall_if  = !i_rst && (stall_all_c || stall_raw_c);
    assign o_stall_id  = !i_rst && (stall_all_c || stall_raw_c);
    assign o_stall_ex  = !i_rst && stall_all_c;
    assign o_stall_mem = !i_rst && stall_all_c;
    assign o_bubble_ex = !i_rst && stall_raw_c;
    assign o_flush     = !i_rst && flush_c;
    assign o_pc_sel    = redirect;
    assign o_pc_target = redirect ? i_mem_jmp_addr : target_q;
    assign o_state     = state_q;
    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

    // State, flush countdown, latched redirect target and performance counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= RUN;
            flush_left_q <= '0;
            target_q     <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            if (redirect) begin
                target_q    <= i_mem_jmp_addr;
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (o_stall_id) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic        use_rs1, use_rs2, ex_we, mem_we, wb_we;
    logic        br;
    logic [63:0] addr;
    logic        req, ready;

    logic        stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush, pc_sel;
    logic [63:0] pc_target;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // behavioural model: pending wait, remaining flush cycles, counters
    bit          m_valid = 0;
    bit          m_wait;
    int          m_left;
    logic [63:0] m_tgt;
    logic [31:0] m_scnt, m_fcnt;

    // sampled DUT values for literal checks
    logic        smp_stall_all, smp_any_ctrl, smp_stall_id, smp_bubble, smp_flush, smp_pc_sel;
    logic [63:0] smp_target;
    logic [1:0]  smp_state, post_state;
    logic [31:0] post_scnt, post_fcnt;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_id_rs1           (id_rs1),
        .i_id_rs2           (id_rs2),
        .i_id_use_rs1       (use_rs1),
        .i_id_use_rs2       (use_rs2),
        .i_ex_rd            (ex_rd),
        .i_ex_reg_write     (ex_we),
        .i_mem_rd           (mem_rd),
        .i_mem_reg_write    (mem_we),
        .i_wb_rd            (wb_rd),
        .i_wb_reg_write     (wb_we),
        .i_mem_branch_taken (br),
        .i_mem_jmp_addr     (addr),
        .i_dmem_req         (req),
        .i_dmem_ready       (ready),
        .o_stall_if         (stall_if),
        .o_stall_id         (stall_id),
        .o_stall_ex         (stall_ex),
        .o_stall_mem        (stall_mem),
        .o_bubble_ex        (bubble_ex),
        .o_flush            (flush),
        .o_pc_sel           (pc_sel),
        .o_pc_target        (pc_target),
        .o_state            (state),
        .o_stall_cnt        (stall_cnt),
        .o_flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // does a used, nonzero source match any writing destination?
    function automatic bit m_raw();
        int writers[$];
        int srcs[$];
        if (ex_we)  writers.push_back(int'(ex_rd));
        if (mem_we) writers.push_back(int'(mem_rd));
        if (wb_we)  writers.push_back(int'(wb_rd));
        if (use_rs1 && id_rs1 != 0) srcs.push_back(int'(id_rs1));
        if (use_rs2 && id_rs2 != 0) srcs.push_back(int'(id_rs2));
        foreach (srcs[i])
            foreach (writers[j])
                if (srcs[i] == writers[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clr();
        rst = 0; id_rs1 = 0; id_rs2 = 0; use_rs1 = 0; use_rs2 = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_we = 0; mem_we = 0; wb_we = 0;
        br = 0; addr = 0; req = 0; ready = 0;
    endtask

    // one clock: inputs are already applied; check at negedge, advance model after posedge
    task automatic cycle();
        bit e_sfront, e_sback, e_bub, e_fl, e_psel;
        logic [63:0] e_tgt, n_tgt;
        logic [1:0]  e_state;
        bit n_wait;
        int n_left;
        logic [31:0] n_scnt, n_fcnt;
        @(negedge clk);
        e_sfront = 0; e_sback = 0; e_bub = 0; e_fl = 0; e_psel = 0;
        e_tgt = m_tgt; n_tgt = m_tgt; n_wait = m_wait; n_left = m_left;
        n_scnt = m_scnt; n_fcnt = m_fcnt;
        e_state = m_wait ? 2'd2 : (m_left > 0 ? 2'd1 : 2'd0);
        if (rst) begin
            n_wait = 0; n_left = 0; n_tgt = 0; n_scnt = 0; n_fcnt = 0;
        end else begin
            if (m_wait) begin
                e_sfront = !ready; e_sback = !ready;
                n_wait = !ready;
            end else if (req && !ready) begin
                e_sfront = 1; e_sback = 1;
                if (m_left == 0) n_wait = 1;
            end else if (br) begin
                e_psel = 1; e_fl = 1; e_tgt = addr; n_tgt = addr;
                n_fcnt = m_fcnt + 1; n_left = FC - 1;
            end else if (m_left > 0) begin
                e_fl = 1; n_left = m_left - 1;
            end else if (m_raw()) begin
                e_sfront = 1; e_bub = 1;
            end
            n_scnt = m_scnt + (e_sfront ? 32'd1 : 32'd0);
        end
        if (m_valid) begin
            chk("stall_if", stall_if, e_sfront);
            chk("stall_id", stall_id, e_sfront);
            chk("stall_ex", stall_ex, e_sback);
            chk("stall_mem", stall_mem, e_sback);
            chk("bubble_ex", bubble_ex, e_bub);
            chk("flush", flush, e_fl);
            chk("pc_sel", pc_sel, e_psel);
            chk("pc_target", pc_target, e_tgt);
            chk("state", state, e_state);
            chk("stall_cnt", stall_cnt, m_scnt);
            chk("flush_cnt", flush_cnt, m_fcnt);
        end
        smp_stall_all = stall_if & stall_id & stall_ex & stall_mem;
        smp_any_ctrl  = stall_if | stall_id | stall_ex | stall_mem | bubble_ex | flush | pc_sel;
        smp_stall_id  = stall_id;
        smp_bubble    = bubble_ex;
        smp_flush     = flush;
        smp_pc_sel    = pc_sel;
        smp_target    = pc_target;
        smp_state     = state;
        @(posedge clk);
        #1;
        if (rst) m_valid = 1;
        m_wait = n_wait; m_left = n_left; m_tgt = n_tgt; m_scnt = n_scnt; m_fcnt = n_fcnt;
        post_state = state; post_scnt = stall_cnt; post_fcnt = flush_cnt;
    endtask

    task automatic do_reset();
        clr(); rst = 1;
        cycle(); cycle();
        rst = 0;
    endtask

    initial begin
        clr();
        do_reset();
        chk("reset_state", post_state, 2'd0);
        chk("reset_stall_cnt", post_scnt, 32'd0);
        chk("reset_flush_cnt", post_fcnt, 32'd0);

        // RAW on EX, then MEM, then WB
        use_rs1 = 1; id_rs1 = 5; ex_rd = 5; ex_we = 1;
        cycle();
        chk("raw_ex_stall_id", smp_stall_id, 1'b1);
        chk("raw_ex_bubble", smp_bubble, 1'b1);
        ex_we = 0; mem_rd = 5; mem_we = 1; cycle();
        mem_we = 0; wb_rd = 5; wb_we = 1; cycle();
        chk("raw_wb_stall_id", smp_stall_id, 1'b1);
        wb_we = 0; cycle();
        chk("raw_clear_stall_id", smp_stall_id, 1'b0);
        chk("raw_stall_cnt", post_scnt, 32'd3);

        // x0 guard
        clr(); id_rs1 = 0; use_rs1 = 1; ex_rd = 0; ex_we = 1; cycle();
        chk("x0_no_stall", smp_stall_id, 1'b0);

        // taken branch
        clr(); br = 1; addr = 64'h1000; cycle();
        chk("br_pc_sel", smp_pc_sel, 1'b1);
        chk("br_target", smp_target, 64'h1000);
        chk("br_flush0", smp_flush, 1'b1);
        br = 0; addr = 64'hdead; cycle();
        chk("br_flush1", smp_flush, 1'b1);
        chk("br_flush1_pc_sel", smp_pc_sel, 1'b0);
        chk("br_flush_cnt", post_fcnt, 32'd1);
        chk("br_state_back", post_state, 2'd0);
        cycle();
        chk("br_flush_done", smp_flush, 1'b0);

        // memory wait: four not-ready cycles then ready
        clr(); req = 1; ready = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("mw_stall_all", smp_stall_all, 1'b1);
            if (i > 0) chk("mw_state", smp_state, 2'd2);
        end
        ready = 1; cycle();
        chk("mw_ready_no_stall", smp_any_ctrl, 1'b0);
        chk("mw_ready_state", post_state, 2'd0);

        // simultaneous mem wait + branch + RAW
        do_reset();
        req = 1; ready = 0; br = 1; addr = 64'h2000;
        use_rs1 = 1; id_rs1 = 7; ex_rd = 7; ex_we = 1;
        cycle();
        chk("sim_stall_all", smp_stall_all, 1'b1);
        chk("sim_no_redirect", smp_pc_sel, 1'b0);
        cycle();
        ready = 1; cycle();
        chk("sim_ready_no_redirect", smp_pc_sel, 1'b0);
        req = 0; cycle();
        chk("sim_redirect", smp_pc_sel, 1'b1);
        chk("sim_target", smp_target, 64'h2000);
        br = 0; cycle();
        chk("sim_flush_no_raw", smp_stall_id, 1'b0);
        chk("sim_stall_cnt", post_scnt, 32'd2);

        // reset during MEM_WAIT
        clr(); req = 1; cycle(); cycle();
        chk("pre_rst_mw_state", post_state, 2'd2);
        rst = 1; cycle();
        chk("rst_mw_ctrl", smp_any_ctrl, 1'b0);
        chk("rst_mw_state", post_state, 2'd0);
        chk("rst_mw_scnt", post_scnt, 32'd0);
        // reset during FLUSH
        clr(); br = 1; addr = 64'h44; cycle();
        br = 0; rst = 1; cycle();
        chk("rst_fl_ctrl", smp_any_ctrl, 1'b0);
        chk("rst_fl_state", post_state, 2'd0);
        chk("rst_fl_fcnt", post_fcnt, 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            id_rs1  = 5'($urandom_range(0, 3));
            id_rs2  = 5'($urandom_range(0, 3));
            use_rs1 = 1'($urandom);
            use_rs2 = 1'($urandom);
            ex_rd   = 5'($urandom_range(0, 3));
            mem_rd  = 5'($urandom_range(0, 3));
            wb_rd   = 5'($urandom_range(0, 3));
            ex_we   = 1'($urandom);
            mem_we  = 1'($urandom);
            wb_we   = 1'($urandom);
            br      = ($urandom_range(0, 5) == 0);
            addr    = {$urandom, $urandom};
            req     = ($urandom_range(0, 3) == 0);
            ready   = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
